// File: rtl/bram_lsu_port_pkg.sv
// Shared encodings for the block-RAM load/store front ends.
package bram_lsu_port_pkg;

    localparam int unsigned LSU_DATA_W = 32;

    typedef logic [1:0] lsu_size_t;

    localparam lsu_size_t SZ_BYTE = 2'b00;
    localparam lsu_size_t SZ_HALF = 2'b01;
    localparam lsu_size_t SZ_WORD = 2'b10;
    localparam lsu_size_t SZ_ILL  = 2'b11;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t IDLE    = 2'd0;
    localparam lsu_state_t RD_WAIT = 2'd1;
    localparam lsu_state_t RESP    = 2'd2;

    // High when the access cannot be issued to the RAM (misaligned or bad size).
    function automatic logic lsu_misaligned(input lsu_size_t size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/bram_lsu_port_if.sv
// CPU-side request/response bus of a block-RAM load/store port.
interface bram_lsu_port_if
    import bram_lsu_port_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic                    req_we;
    lsu_size_t               req_size;
    logic                    req_unsigned;
    logic [LSU_DATA_W-1:0]   req_wdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [LSU_DATA_W-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/bram_lsu_port_lane_align.sv
// Byte-lane steering shared by both RAM port front ends: store replication and
// byte enables on one side, load extraction and extension on the other.
module lsu_lane_align
    import bram_lsu_port_pkg::*;
(
    input  lsu_size_t              st_size,
    input  logic [1:0]             st_lane,
    input  logic [LSU_DATA_W-1:0]  st_wdata,
    output logic [LSU_DATA_W-1:0]  st_din,
    output logic [3:0]             st_be,
    input  lsu_size_t              ld_size,
    input  logic [1:0]             ld_lane,
    input  logic                   ld_unsigned,
    input  logic [LSU_DATA_W-1:0]  ld_dout,
    output logic [LSU_DATA_W-1:0]  ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: replicate the right-justified data into every lane it may land in.
    always_comb begin
        st_din = st_wdata;
        st_be  = '0;
        case (st_size)
            SZ_BYTE: begin
                st_din = {4{st_wdata[7:0]}};
                st_be  = 4'b0001 << st_lane;
            end
            SZ_HALF: begin
                st_din = {2{st_wdata[15:0]}};
                st_be  = st_lane[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: st_be = '1;
            default: st_be = '0;
        endcase
    end

    // Load side: pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        ld_byte = ld_dout[{ld_lane, 3'b000} +: 8];
        ld_half = ld_lane[1] ? ld_dout[31:16] : ld_dout[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default: ld_data = ld_dout;
        endcase
    end

endmodule

// File: rtl/bram_lsu_port.sv
// Load/store front end for one port of the dual-clock byte-write block RAM.
// One request outstanding; loads wait READ_LATENCY cycles for RAM data.
module bram_lsu_port
    import bram_lsu_port_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clka,
    input  logic                   rstb,
    bram_lsu_port_if.slave         lsu,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [LSU_DATA_W-1:0]  mem_din,
    output logic [3:0]             mem_we,
    output logic                   mem_en,
    output logic                   mem_regce,
    output logic                   mem_rst,
    input  logic [LSU_DATA_W-1:0]  mem_dout
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_lsu_port: READ_LATENCY must be 1 or 2");
    end

    // Down-counter start value; a single bit covers both legal latencies.
    localparam logic CNT_INIT = (READ_LATENCY == 2);

    lsu_state_t             state_q, state_d;
    logic                   cnt_q, cnt_d;
    logic [1:0]             lane_q, lane_d;
    lsu_size_t              size_q, size_d;
    logic                   uns_q, uns_d;
    logic [LSU_DATA_W-1:0]  rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic                   req_bad;
    logic [LSU_DATA_W-1:0]  st_din;
    logic [3:0]             st_be;
    logic [LSU_DATA_W-1:0]  ld_data;

    lsu_lane_align u_align (
        .st_size     (lsu.req_size),
        .st_lane     (lsu.req_addr[1:0]),
        .st_wdata    (lsu.req_wdata),
        .st_din      (st_din),
        .st_be       (st_be),
        .ld_size     (size_q),
        .ld_lane     (lane_q),
        .ld_unsigned (uns_q),
        .ld_dout     (mem_dout),
        .ld_data     (ld_data)
    );

    // Handshake and RAM request are driven straight from the bus in the accept cycle.
    always_comb begin
        lsu.req_ready = ~rstb & ((state_q == IDLE) | ((state_q == RESP) & lsu.rsp_ready));
        accept        = lsu.req_valid & lsu.req_ready;
        req_bad       = lsu_misaligned(lsu.req_size, lsu.req_addr[1:0]);
        mem_addr      = lsu.req_addr[ADDR_WIDTH+1:2];
        mem_din       = st_din;
        mem_en        = accept & ~req_bad;
        mem_we        = (accept & ~req_bad & lsu.req_we) ? st_be : '0;
        mem_regce     = 1'b1;
        mem_rst       = rstb;
        lsu.rsp_valid = (state_q == RESP);
        lsu.rsp_rdata = rdata_q;
        lsu.rsp_err   = err_q;
    end

    // Next state: a new accept overrides the RESP exit so handshakes chain without a bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: ;
            RD_WAIT: begin
                if (!cnt_q) begin
                    rdata_d = ld_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = 1'b0;
                end
            end
            RESP: begin
                if (lsu.rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            lane_d  = lsu.req_addr[1:0];
            size_d  = lsu.req_size;
            uns_d   = lsu.req_unsigned;
            rdata_d = '0;
            err_d   = req_bad;
            if (!req_bad && !lsu.req_we) begin
                state_d = RD_WAIT;
                cnt_d   = CNT_INIT;
            end else begin
                state_d = RESP;
            end
        end
    end

    // State registers; reset drops any in-flight read so stale RAM data is never captured.
    always_ff @(posedge clka) begin
        if (rstb) begin
            state_q <= IDLE;
            cnt_q   <= 1'b0;
            lane_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_bram_lsu_port.sv
// Bench for bram_lsu_port: one instance per legal read latency, driven in
// lockstep, each checked every cycle against a transaction-level model.
module tb_bram_lsu_port;

    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic clka = 1'b0;
    logic rstb = 1'b1;
    always #5 clka = ~clka;

    logic            req_valid = 1'b0;
    logic            req_we = 1'b0;
    logic            req_unsigned = 1'b0;
    logic            rsp_ready = 1'b1;
    logic [AW+1:0]   req_addr = '0;
    logic [1:0]      req_size = 2'b00;
    logic [31:0]     req_wdata = '0;

    bram_lsu_port_if #(.ADDR_WIDTH(AW)) u_if0 ();
    bram_lsu_port_if #(.ADDR_WIDTH(AW)) u_if1 ();

    assign u_if0.req_valid    = req_valid;
    assign u_if0.req_addr     = req_addr;
    assign u_if0.req_we       = req_we;
    assign u_if0.req_size     = req_size;
    assign u_if0.req_unsigned = req_unsigned;
    assign u_if0.req_wdata    = req_wdata;
    assign u_if0.rsp_ready    = rsp_ready;
    assign u_if1.req_valid    = req_valid;
    assign u_if1.req_addr     = req_addr;
    assign u_if1.req_we       = req_we;
    assign u_if1.req_size     = req_size;
    assign u_if1.req_unsigned = req_unsigned;
    assign u_if1.req_wdata    = req_wdata;
    assign u_if1.rsp_ready    = rsp_ready;

    logic [1:0]    o_req_ready, o_rsp_valid, o_rsp_err, o_mem_en, o_mem_regce, o_mem_rst;
    logic [31:0]   o_rsp_rdata [2];
    logic [AW-1:0] o_mem_addr [2];
    logic [31:0]   o_mem_din [2];
    logic [3:0]    o_mem_we [2];
    logic [31:0]   i_mem_dout [2];

    assign o_req_ready[0] = u_if0.req_ready;
    assign o_rsp_valid[0] = u_if0.rsp_valid;
    assign o_rsp_err[0]   = u_if0.rsp_err;
    assign o_rsp_rdata[0] = u_if0.rsp_rdata;
    assign o_req_ready[1] = u_if1.req_ready;
    assign o_rsp_valid[1] = u_if1.rsp_valid;
    assign o_rsp_err[1]   = u_if1.rsp_err;
    assign o_rsp_rdata[1] = u_if1.rsp_rdata;

    bram_lsu_port #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut0 (
        .clka(clka), .rstb(rstb), .lsu(u_if0),
        .mem_addr(o_mem_addr[0]), .mem_din(o_mem_din[0]), .mem_we(o_mem_we[0]),
        .mem_en(o_mem_en[0]), .mem_regce(o_mem_regce[0]), .mem_rst(o_mem_rst[0]),
        .mem_dout(i_mem_dout[0])
    );

    bram_lsu_port #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_dut1 (
        .clka(clka), .rstb(rstb), .lsu(u_if1),
        .mem_addr(o_mem_addr[1]), .mem_din(o_mem_din[1]), .mem_we(o_mem_we[1]),
        .mem_en(o_mem_en[1]), .mem_regce(o_mem_regce[1]), .mem_rst(o_mem_rst[1]),
        .mem_dout(i_mem_dout[1])
    );

    // Behavioural RAMs: read-first, latency 1 (g=0) or with output register (g=1).
    for (genvar g = 0; g < 2; g++) begin : g_ram
        logic [31:0] ram [DEPTH];
        logic [31:0] rd_q = '0;
        logic [31:0] pipe_q = '0;
        initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        always @(posedge clka) begin
            if (o_mem_en[g]) begin
                rd_q <= ram[o_mem_addr[g]];
                for (int b = 0; b < 4; b++)
                    if (o_mem_we[g][b]) ram[o_mem_addr[g]][8*b +: 8] <= o_mem_din[g][8*b +: 8];
            end
            pipe_q <= o_mem_rst[g] ? 32'h0 : rd_q;
        end
        assign i_mem_dout[g] = (g == 0) ? rd_q : pipe_q;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // ---------------- transaction-level model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit m_bad(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'b11) return 1'b1;
        return (int'(lo) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_lanes(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (i >= int'(lo) && i < int'(lo) + nbytes(sz)) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] m_repl(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % nbytes(sz)))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lo, input logic uns);
        logic [31:0] v;
        int nb;
        if (sz == 2'b10) return w;
        nb = nbytes(sz);
        v = (w >> (8 * int'(lo))) & ((32'd1 << (8 * nb)) - 32'd1);
        if (!uns && v >= (32'd1 << (8 * nb - 1))) v = v - (32'd1 << (8 * nb));
        return v;
    endfunction

    bit          started = 1'b0;
    int          cyc = 0;
    bit          m_pend [2] = '{0, 0};
    int          m_due [2] = '{0, 0};
    logic [31:0] m_data [2];
    logic        m_err [2];
    logic [31:0] shadow [DEPTH];

    int          acc_cyc [2] = '{0, 0};
    int          hs_cyc [2] = '{0, 0};
    int          rsp_cnt [2] = '{0, 0};
    logic [31:0] acc_din [2];
    logic [3:0]  acc_we [2];
    logic [AW-1:0] acc_addr [2];
    logic        acc_en [2];
    logic [31:0] hs_rdata [2];
    logic        hs_err [2];

    // Compare process: check every output every cycle, then advance the model.
    always @(negedge clka) begin
        if (started) begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                bit exp_valid, exp_ready, acc, bad;
                logic [3:0] exp_we;
                exp_valid = m_pend[k] && (m_due[k] == 0);
                exp_ready = !rstb && (!m_pend[k] || (exp_valid && rsp_ready));
                acc       = req_valid && exp_ready;
                bad       = m_bad(req_size, req_addr[1:0]);
                exp_we    = (acc && !bad && req_we) ? m_lanes(req_size, req_addr[1:0]) : 4'h0;

                chk("rsp_valid", k, 32'(o_rsp_valid[k]), 32'(exp_valid));
                chk("req_ready", k, 32'(o_req_ready[k]), 32'(exp_ready));
                chk("mem_en", k, 32'(o_mem_en[k]), 32'(acc && !bad));
                chk("mem_we", k, 32'(o_mem_we[k]), 32'(exp_we));
                chk("mem_rst", k, 32'(o_mem_rst[k]), 32'(rstb));
                chk("mem_regce", k, 32'(o_mem_regce[k]), 32'd1);
                if (exp_valid) begin
                    chk("rsp_rdata", k, o_rsp_rdata[k], m_data[k]);
                    chk("rsp_err", k, 32'(o_rsp_err[k]), 32'(m_err[k]));
                end
                if (acc && !bad) begin
                    chk("mem_addr", k, 32'(o_mem_addr[k]), 32'(req_addr >> 2));
                    if (req_we) chk("mem_din", k, o_mem_din[k], m_repl(req_size, req_wdata));
                end

                if (o_req_ready[k] && req_valid) begin
                    acc_cyc[k]  = cyc;
                    acc_din[k]  = o_mem_din[k];
                    acc_we[k]   = o_mem_we[k];
                    acc_addr[k] = o_mem_addr[k];
                    acc_en[k]   = o_mem_en[k];
                end
                if (o_rsp_valid[k] && rsp_ready) begin
                    rsp_cnt[k]++;
                    hs_cyc[k]   = cyc;
                    hs_rdata[k] = o_rsp_rdata[k];
                    hs_err[k]   = o_rsp_err[k];
                end

                if (rstb) begin
                    m_pend[k] = 1'b0;
                end else begin
                    if (exp_valid) begin
                        if (rsp_ready) m_pend[k] = 1'b0;
                    end else if (m_pend[k]) begin
                        m_due[k]--;
                    end
                    if (acc) begin
                        m_pend[k] = 1'b1;
                        m_due[k]  = 0;
                        m_data[k] = 32'h0;
                        m_err[k]  = bad;
                        if (!bad && !req_we) begin
                            m_due[k]  = k + 1;
                            m_data[k] = m_load(shadow[req_addr[AW+1:2]], req_size, req_addr[1:0], req_unsigned);
                        end
                        if (!bad && req_we && k == 1) begin
                            for (int b = 0; b < 4; b++)
                                if (exp_we[b])
                                    shadow[req_addr[AW+1:2]][8*b +: 8] = m_repl(req_size, req_wdata) >> (8 * b);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (o_req_ready == 2'b11 && o_rsp_valid == 2'b00) return;
            tick();
        end
        timeout_fail("wait_idle");
    endtask

    task automatic wait_rsp(input int want0, input int want1, input string name);
        for (int i = 0; i < 40; i++) begin
            if (rsp_cnt[0] >= want0 && rsp_cnt[1] >= want1) return;
            tick();
        end
        timeout_fail(name);
    endtask

    task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [AW+1:0] addr, input logic [31:0] wd);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    endtask

    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] addr, input logic [31:0] wd);
        int c0, c1;
        rsp_ready = 1'b1;
        wait_idle();
        c0 = rsp_cnt[0];
        c1 = rsp_cnt[1];
        set_req(we, sz, uns, addr, wd);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rsp(c0 + 1, c1 + 1, "rsp_wait");
    endtask

    // Literal expectations for the last response; lat0/lat1 are accept-to-valid cycles.
    task automatic expect_rsp(input string nm, input logic [31:0] rd, input logic er,
                              input int lat0, input int lat1);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_rdata"}, k, hs_rdata[k], rd);
            chk({nm, "_err"}, k, 32'(hs_err[k]), 32'(er));
            chk({nm, "_latency"}, k, 32'(hs_cyc[k] - acc_cyc[k]), 32'((k == 0) ? lat0 : lat1));
        end
    endtask

    task automatic expect_acc(input string nm, input logic en, input logic [3:0] we,
                              input logic [31:0] din, input logic [AW-1:0] addr);
        for (int k = 0; k < 2; k++) begin
            chk({nm, "_en"}, k, 32'(acc_en[k]), 32'(en));
            chk({nm, "_we"}, k, 32'(acc_we[k]), 32'(we));
            if (en && we != 4'h0) chk({nm, "_din"}, k, acc_din[k], din);
            if (en) chk({nm, "_addr"}, k, 32'(acc_addr[k]), 32'(addr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        rstb = 1'b1;
        repeat (3) tick();
        started = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("reset_rsp_valid", k, 32'(o_rsp_valid[k]), 32'd0);
            chk("reset_mem_en", k, 32'(o_mem_en[k]), 32'd0);
            chk("reset_mem_rst", k, 32'(o_mem_rst[k]), 32'd1);
        end
        rstb = 1'b0;
        tick();

        do_op(1'b1, 2'b10, 1'b0, 15'h008, 32'hDEADBEEF);
        expect_acc("st_word", 1'b1, 4'b1111, 32'hDEADBEEF, 13'd2);
        expect_rsp("st_word", 32'h0, 1'b0, 1, 1);

        do_op(1'b1, 2'b00, 1'b0, 15'h00B, 32'h0000005A);
        expect_acc("st_byte5a", 1'b1, 4'b1000, 32'h5A5A5A5A, 13'd2);
        do_op(1'b0, 2'b00, 1'b0, 15'h00B, 32'h0);
        expect_rsp("ld_byte5a", 32'h0000005A, 1'b0, 2, 3);

        do_op(1'b1, 2'b00, 1'b0, 15'h00B, 32'h000000A5);
        expect_acc("st_bytea5", 1'b1, 4'b1000, 32'hA5A5A5A5, 13'd2);
        do_op(1'b0, 2'b00, 1'b0, 15'h00B, 32'h0);
        expect_rsp("ld_bytea5_s", 32'hFFFFFFA5, 1'b0, 2, 3);
        do_op(1'b0, 2'b00, 1'b1, 15'h00B, 32'h0);
        expect_rsp("ld_bytea5_u", 32'h000000A5, 1'b0, 2, 3);
        do_op(1'b0, 2'b00, 1'b0, 15'h009, 32'h0);
        expect_rsp("ld_byte1_s", 32'hFFFFFFBE, 1'b0, 2, 3);

        do_op(1'b1, 2'b10, 1'b0, 15'h004, 32'h80011234);
        do_op(1'b0, 2'b01, 1'b0, 15'h006, 32'h0);
        expect_acc("ld_half", 1'b1, 4'b0000, 32'h0, 13'd1);
        expect_rsp("ld_half_s", 32'hFFFF8001, 1'b0, 2, 3);
        do_op(1'b0, 2'b01, 1'b1, 15'h006, 32'h0);
        expect_rsp("ld_half_u", 32'h00008001, 1'b0, 2, 3);

        do_op(1'b0, 2'b10, 1'b0, 15'h002, 32'h0);
        expect_acc("ld_word_mis", 1'b0, 4'b0000, 32'h0, 13'd0);
        expect_rsp("ld_word_mis", 32'h0, 1'b1, 1, 1);
        do_op(1'b0, 2'b11, 1'b0, 15'h000, 32'h0);
        expect_acc("size_ill", 1'b0, 4'b0000, 32'h0, 13'd0);
        expect_rsp("size_ill", 32'h0, 1'b1, 1, 1);
        do_op(1'b1, 2'b01, 1'b0, 15'h001, 32'h0000FFFF);
        expect_acc("st_half_mis", 1'b0, 4'b0000, 32'h0, 13'd0);
        expect_rsp("st_half_mis", 32'h0, 1'b1, 1, 1);

        do_op(1'b1, 2'b01, 1'b0, 15'h00E, 32'h1234BEEF);
        expect_acc("st_half_hi", 1'b1, 4'b1100, 32'hBEEFBEEF, 13'd3);
        do_op(1'b0, 2'b10, 1'b0, 15'h00C, 32'h0);
        expect_rsp("ld_word_c", 32'hBEEF0000, 1'b0, 2, 3);

        // Response held off: a store waits on req_valid and is taken on the releasing edge.
        rsp_ready = 1'b1;
        wait_idle();
        rsp_ready = 1'b0;
        c0 = rsp_cnt[0];
        c1 = rsp_cnt[1];
        set_req(1'b0, 2'b10, 1'b0, 15'h004, 32'h0);
        req_valid = 1'b1;
        tick();
        set_req(1'b1, 2'b10, 1'b0, 15'h030, 32'hCAFEF00D);
        repeat (8) tick();
        for (int k = 0; k < 2; k++) chk("hold_no_rsp", k, 32'(rsp_cnt[k] - ((k == 0) ? c0 : c1)), 32'd0);
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("hold_rdata", k, hs_rdata[k], 32'h80011234);
            chk("hold_err", k, 32'(hs_err[k]), 32'd0);
            chk("same_cycle_accept", k, 32'(acc_cyc[k] - hs_cyc[k]), 32'd0);
        end
        expect_acc("hold_next_st", 1'b1, 4'b1111, 32'hCAFEF00D, 13'd12);
        wait_rsp(c0 + 2, c1 + 2, "hold_store_rsp");
        do_op(1'b0, 2'b10, 1'b0, 15'h030, 32'h0);
        expect_rsp("ld_after_hold", 32'hCAFEF00D, 1'b0, 2, 3);

        // Back-to-back byte stores, one per cycle.
        rsp_ready = 1'b1;
        wait_idle();
        c0 = rsp_cnt[0];
        c1 = rsp_cnt[1];
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 2'b00, 1'b0, 15'(32'h020 + i), 32'(8'h11 * (i + 1)));
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) chk("b2b_rsp_count", k, 32'(rsp_cnt[k] - ((k == 0) ? c0 : c1)), 32'd4);
        do_op(1'b0, 2'b10, 1'b0, 15'h020, 32'h0);
        expect_rsp("ld_b2b", 32'h44332211, 1'b0, 2, 3);

        // Reset while the read is outstanding: no response may ever appear for it.
        rsp_ready = 1'b1;
        wait_idle();
        c0 = rsp_cnt[0];
        c1 = rsp_cnt[1];
        set_req(1'b0, 2'b10, 1'b0, 15'h020, 32'h0);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        rstb = 1'b1;
        repeat (2) tick();
        rstb = 1'b0;
        repeat (6) tick();
        for (int k = 0; k < 2; k++) chk("reset_drop_rsp", k, 32'(rsp_cnt[k] - ((k == 0) ? c0 : c1)), 32'd0);
        do_op(1'b0, 2'b10, 1'b0, 15'h004, 32'h0);
        expect_rsp("ld_after_reset", 32'h80011234, 1'b0, 2, 3);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
